// File: rtl/dca_lsu_row_packer_pkg.sv
// Shared types and width derivations for the DCA LSU row packer.
package dca_lsu_row_packer_pkg;

    // Command fields are stored at a fixed width; the top level slices them back down.
    localparam int unsigned CMD_FIELD_W = 8;

    typedef struct packed {
        logic [CMD_FIELD_W-1:0] offset;
        logic [CMD_FIELD_W-1:0] count;
        logic [CMD_FIELD_W-1:0] ch;
    } cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StEmit
    } state_e;

    function automatic int unsigned calc_epb(input int unsigned bw_data,
                                             input int unsigned bw_elem);
        return bw_data / bw_elem;
    endfunction

    function automatic int unsigned calc_bw_ofs(input int unsigned epb);
        int unsigned w;
        w = $clog2(epb);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned calc_bw_cnt(input int unsigned row_elements);
        return $clog2(row_elements + 1);
    endfunction

    function automatic int unsigned calc_bw_ch(input int unsigned num_ch);
        int unsigned w;
        w = $clog2(num_ch);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dca_lsu_cmd_fifo.sv
// Synchronous command FIFO with flush; exposes the head and the entry behind it.
module dca_lsu_cmd_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [WIDTH-1:0] o_next,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_multi
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW-1:0]    w_rd_next;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_rd_next = r_rd_ptr + AW'(1);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_next  = r_mem[w_rd_next];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_multi = (r_count > (AW+1)'(1));

    // Storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; flush behaves like reset.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dca_lsu_row_packer.sv
// Load-side row assembler: queues row commands, extracts elements from read beats,
// packs and zero-pads them into a tagged output row.
module dca_lsu_row_packer
    import dca_lsu_row_packer_pkg::*;
#(
    parameter int unsigned BW_AXI_DATA  = 32,
    parameter int unsigned BW_ELEMENT   = 8,
    parameter int unsigned ROW_ELEMENTS = 4,
    parameter int unsigned CMD_DEPTH    = 4,
    parameter int unsigned NUM_CH       = 2,
    localparam int unsigned EPB    = calc_epb(BW_AXI_DATA, BW_ELEMENT),
    localparam int unsigned BW_OFS = calc_bw_ofs(EPB),
    localparam int unsigned BW_CNT = calc_bw_cnt(ROW_ELEMENTS),
    localparam int unsigned BW_CH  = calc_bw_ch(NUM_CH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [BW_OFS-1:0]                  cmd_offset,
    input  logic [BW_CNT-1:0]                  cmd_count,
    input  logic [BW_CH-1:0]                   cmd_ch,
    input  logic                               rdata_valid,
    output logic                               rdata_ready,
    input  logic [BW_AXI_DATA-1:0]             rdata,
    input  logic                               rdata_last,
    output logic                               row_valid,
    input  logic                               row_ready,
    output logic [ROW_ELEMENTS*BW_ELEMENT-1:0] row_data,
    output logic [BW_CNT-1:0]                  row_count,
    output logic [BW_CH-1:0]                   row_ch,
    output logic                               busy,
    output logic                               err_short,
    output logic                               err_cmd
);

    cmd_t   w_push_cmd;
    cmd_t   w_head;
    cmd_t   w_next;
    logic   w_empty;
    logic   w_full;
    logic   w_multi;
    logic   w_legal;
    logic   w_push;
    logic   w_pop;
    logic   w_latch_head;
    logic   w_latch_next;
    logic   w_beat;

    state_e r_state;
    state_e w_state_nxt;
    cmd_t   r_cmd;
    logic   [BW_CNT-1:0] r_fill;
    logic   [BW_CNT-1:0] w_fill_nxt;
    logic   r_first;
    logic   [ROW_ELEMENTS*BW_ELEMENT-1:0] r_row;
    logic   [ROW_ELEMENTS*BW_ELEMENT-1:0] w_row;
    logic   r_err_short;
    logic   r_err_cmd;
    int unsigned w_idx;
    int unsigned w_cnt;
    int unsigned w_ofs;

    // Illegal counts still complete the handshake but are never queued.
    assign w_legal    = (cmd_count != '0) && (cmd_count <= BW_CNT'(ROW_ELEMENTS));
    assign cmd_ready  = !w_full;
    assign w_push     = cmd_valid && cmd_ready && w_legal && !clear;
    assign w_push_cmd = '{offset: CMD_FIELD_W'(cmd_offset),
                          count:  CMD_FIELD_W'(cmd_count),
                          ch:     CMD_FIELD_W'(cmd_ch)};

    dca_lsu_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (clear),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_multi (w_multi)
    );

    // Append this beat's candidate elements at the fill position, dropping overflow.
    always_comb begin
        w_cnt = 32'(r_cmd.count);
        w_ofs = 32'(r_cmd.offset) % EPB;
        w_row = r_row;
        w_idx = 32'(r_fill);
        for (int unsigned j = 0; j < EPB; j++) begin
            if ((!r_first || (j >= w_ofs)) && (w_idx < w_cnt)) begin
                w_row[w_idx*BW_ELEMENT +: BW_ELEMENT] = rdata[j*BW_ELEMENT +: BW_ELEMENT];
                w_idx = w_idx + 1;
            end
        end
        w_fill_nxt = BW_CNT'(w_idx);
    end

    // Next-state and control decode; the command stays queued until its row is taken.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_latch_head = 1'b0;
        w_latch_next = 1'b0;
        w_beat       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_latch_head = 1'b1;
                    w_state_nxt  = StCollect;
                end
            end
            StCollect: begin
                if (rdata_valid) begin
                    w_beat = 1'b1;
                    if (rdata_last) begin
                        w_state_nxt = StEmit;
                    end
                end
            end
            StEmit: begin
                if (row_ready) begin
                    w_pop = 1'b1;
                    if (w_multi) begin
                        w_latch_next = 1'b1;
                        w_state_nxt  = StCollect;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State, latched command, partial row and short-row flag.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= StIdle;
            r_cmd       <= '0;
            r_fill      <= '0;
            r_first     <= 1'b0;
            r_row       <= '0;
            r_err_short <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_head || w_latch_next) begin
                r_cmd   <= w_latch_head ? w_head : w_next;
                r_fill  <= '0;
                r_first <= 1'b1;
                r_row   <= '0;
            end else if (w_beat) begin
                r_row   <= w_row;
                r_fill  <= w_fill_nxt;
                r_first <= 1'b0;
                if (rdata_last && (32'(w_fill_nxt) < w_cnt)) begin
                    r_err_short <= 1'b1;
                end
            end
        end
    end

    // Sticky flag for dropped commands.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_err_cmd <= 1'b0;
        end else if (cmd_valid && cmd_ready && !w_legal) begin
            r_err_cmd <= 1'b1;
        end
    end

    assign rdata_ready = (r_state == StCollect);
    assign row_valid   = (r_state == StEmit);
    assign row_data    = row_valid ? r_row : '0;
    assign row_count   = row_valid ? r_cmd.count[BW_CNT-1:0] : '0;
    assign row_ch      = row_valid ? r_cmd.ch[BW_CH-1:0] : '0;
    assign busy        = !w_empty || (r_state != StIdle);
    assign err_short   = r_err_short;
    assign err_cmd     = r_err_cmd;

endmodule
